// File: rtl/led_run_ctrl.sv
// led_run_ctrl: control stage ahead of the 8-bit running-LED pattern.
// Debounces the raw mode and speed buttons, keeps the shift direction (mode)
// and the rate setting (speed_sel), and divides clk down to a one-cycle
// step_tick that advances the LED pattern.
// Optional feature macro: LED_RUN_CTRL_AUTO_REV_EN -- when defined, the
// direction also reverses by itself after every 16 step ticks.
module led_run_ctrl #(
  parameter int DEB_CYCLES = 240000,
  parameter int DIV_BASE   = 12000000,
  parameter int CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_n,
  input  logic       key_speed_n,
  input  logic       run_en,
  output logic       mode,
  output logic       step_tick,
  output logic [1:0] speed_sel
);

  localparam int NUM_KEYS  = 2;
  localparam int KEY_MODE  = 0;
  localparam int KEY_SPEED = 1;
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_BASE_C = CNT_W'(DIV_BASE);

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_press;

  logic             mode_reg, mode_next;
  logic             tick_reg, tick_next;
  logic [1:0]       speed_sel_reg, speed_sel_next;
  logic [CNT_W-1:0] div_cnt_reg, div_cnt_next;
  logic [CNT_W-1:0] period;

  assign key_raw = {key_speed_n, key_mode_n};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic [CNT_W-1:0] deb_cnt_reg;

      // Two-flop synchroniser, then accept a new level only after it differs for DEB_CYCLES clocks
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg   <= 1'b1;
          sync2_reg   <= 1'b1;
          deb_reg     <= 1'b1;
          deb_cnt_reg <= '0;
        end else begin
          sync1_reg <= key_raw[gi];
          sync2_reg <= sync1_reg;
          if (sync2_reg == deb_reg) begin
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            deb_reg     <= sync2_reg;
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 1'b1;
          end
        end
      end

      // A press is the debounced 1->0 edge, flagged in the cycle the level is accepted
      assign key_press[gi] = deb_reg & ~sync2_reg & (deb_cnt_reg == DEB_LAST);
    end
  endgenerate

  // Each speed step halves the step period
  assign period = DIV_BASE_C >> speed_sel_reg;

  // Rate setting advances on each speed press and wraps from 3 back to 0
  assign speed_sel_next = speed_sel_reg + {1'b0, key_press[KEY_SPEED]};

  // Divider: paused or restarted at 0; tick is issued for the cycle after the last count
  always_comb begin
    div_cnt_next = div_cnt_reg;
    tick_next    = 1'b0;
    if (!run_en || key_press[KEY_SPEED]) begin
      div_cnt_next = '0;
    end else if (div_cnt_reg == period - 1'b1) begin
      div_cnt_next = '0;
      tick_next    = 1'b1;
    end else begin
      div_cnt_next = div_cnt_reg + 1'b1;
    end
  end

`ifdef LED_RUN_CTRL_AUTO_REV_EN
  logic [3:0] rev_cnt_reg, rev_cnt_next;

  // Direction flips on a mode press or on every 16th step; a press restarts the step count
  always_comb begin
    mode_next    = mode_reg;
    rev_cnt_next = rev_cnt_reg;
    if (key_press[KEY_MODE]) begin
      mode_next    = ~mode_reg;
      rev_cnt_next = '0;
    end else if (tick_next) begin
      if (rev_cnt_reg == 4'd15) begin
        mode_next    = ~mode_reg;
        rev_cnt_next = '0;
      end else begin
        rev_cnt_next = rev_cnt_reg + 4'd1;
      end
    end
  end

  // Step counter for automatic reversal
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rev_cnt_reg <= '0;
    end else begin
      rev_cnt_reg <= rev_cnt_next;
    end
  end
`else
  // Direction flips only on a mode press
  always_comb begin
    mode_next = mode_reg ^ key_press[KEY_MODE];
  end
`endif

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= 1'b0;
      tick_reg      <= 1'b0;
      speed_sel_reg <= 2'd0;
      div_cnt_reg   <= '0;
    end else begin
      mode_reg      <= mode_next;
      tick_reg      <= tick_next;
      speed_sel_reg <= speed_sel_next;
      div_cnt_reg   <= div_cnt_next;
    end
  end

  assign mode      = mode_reg;
  assign step_tick = tick_reg;
  assign speed_sel = speed_sel_reg;

endmodule

// File: tb/tb_led_run_ctrl.sv
// tb_led_run_ctrl: table vectors, directed multi-cycle sequences and a random
// run compared each cycle against a window/arithmetic reference model.
module tb_led_run_ctrl;

  localparam int DEB  = 4;
  localparam int DIV  = 16;
  localparam int CW   = 8;
  localparam int HIST = 16384;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode_n = 1'b1;
  logic       key_speed_n = 1'b1;
  logic       run_en = 1'b0;
  logic       mode;
  logic       step_tick;
  logic [1:0] speed_sel;

  led_run_ctrl #(.DEB_CYCLES(DEB), .DIV_BASE(DIV), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_mode_n (key_mode_n),
    .key_speed_n(key_speed_n),
    .run_en     (run_en),
    .mode       (mode),
    .step_tick  (step_tick),
    .speed_sel  (speed_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         k = 0;         // index of the last clock edge
  int         rst_edge = 0;  // edge index at which reset was last applied
  int         t0 = 0;        // edge at which the current step period was (re)started
  bit         m_deb [2];
  logic       m_mode;
  logic [1:0] m_spd;
  logic       m_tick;
`ifdef LED_RUN_CTRL_AUTO_REV_EN
  int         m_tc;
`endif
  bit         raw_hist [2][HIST];

  typedef struct {
    logic       km;
    logic       ks;
    logic       run;
    int         n;
    logic       exp_mode;
    logic [1:0] exp_spd;
    logic       exp_tick;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, k);
    end
  endtask

  task automatic model_reset();
    rst_edge = k;
    t0       = k;
    m_deb[0] = 1'b1;
    m_deb[1] = 1'b1;
    m_mode   = 1'b0;
    m_spd    = 2'd0;
    m_tick   = 1'b0;
`ifdef LED_RUN_CTRL_AUTO_REV_EN
    m_tc     = 0;
`endif
  endtask

  // Level seen by the debouncer at edge j: the raw key two edges earlier, or released after reset
  function automatic bit seen(input int key, input int j);
    if (j - 2 >= rst_edge + 1) return raw_hist[key][j-2];
    return 1'b1;
  endfunction

  task automatic model_edge();
    bit press [2];
    bit flip;
    int per;
    k++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    raw_hist[0][k] = key_mode_n;
    raw_hist[1][k] = key_speed_n;
    // A key level is accepted once the last DEB seen samples all differ from it
    for (int key = 0; key < 2; key++) begin
      flip = 1'b1;
      for (int j = k - DEB + 1; j <= k; j++) begin
        if (j <= rst_edge) flip = 1'b0;
        else if (seen(key, j) == m_deb[key]) flip = 1'b0;
      end
      press[key] = flip && m_deb[key];
      if (flip) m_deb[key] = !m_deb[key];
    end
    per = DIV >> m_spd;
    if (!run_en || press[1]) begin
      t0     = k;
      m_tick = 1'b0;
    end else begin
      m_tick = ((k - t0) % per) == 0;
    end
    if (press[1]) m_spd = m_spd + 2'd1;
`ifdef LED_RUN_CTRL_AUTO_REV_EN
    if (press[0]) begin
      m_mode = !m_mode;
      m_tc   = 0;
    end else if (m_tick) begin
      m_tc++;
      if (m_tc == 16) begin
        m_mode = !m_mode;
        m_tc   = 0;
      end
    end
`else
    if (press[0]) m_mode = !m_mode;
`endif
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_mode", 8'(mode), 8'(m_mode));
    chk("model_speed", 8'(speed_sel), 8'(m_spd));
    chk("model_tick", 8'(step_tick), 8'(m_tick));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(input string name, input int limit, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step_tick && n < limit);
    chk(name, 8'(step_tick), 8'd1);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_mode"}, 8'(mode), 8'd0);
    chk({tag, "_speed"}, 8'(speed_sel), 8'd0);
    chk({tag, "_tick"}, 8'(step_tick), 8'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int cnt;
    int hm, hs, hr;
    int plist [4];
    logic [1:0] prev_spd;
    logic pm;

    plist = '{8, 4, 2, 16};
    model_reset();

    // km ks run  n   mode spd tick   (run_en=0, so no ticks)
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 3,  1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 5,  1'b0, 2'd0, 1'b0};  // mode key low, not yet accepted
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1,  1'b1, 2'd0, 1'b0};  // 6th clock after fall: toggle
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 4,  1'b1, 2'd0, 1'b0};  // held: single toggle
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 2'd0, 1'b0};  // release ignored
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 3,  1'b1, 2'd0, 1'b0};  // 3-clock glitch
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 2'd0, 1'b0};  // glitch rejected
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 5,  1'b1, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1,  1'b1, 2'd1, 1'b0};  // speed 0->1
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 10, 1'b1, 2'd1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 5,  1'b1, 2'd1, 1'b0};  // both keys fall together
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 2'd2, 1'b0};  // both act on the same edge
    tbl[12] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 2'd2, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 6,  1'b0, 2'd3, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 2'd3, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 6,  1'b0, 2'd0, 1'b0};  // wrap 3->0
    tbl[16] = '{1'b1, 1'b1, 1'b0, 10, 1'b0, 2'd0, 1'b0};

    // Reset state
    repeat (3) cyc();
    chk("reset_mode", 8'(mode), 8'd0);
    chk("reset_speed", 8'(speed_sel), 8'd0);
    chk("reset_tick", 8'(step_tick), 8'd0);
    rst_n = 1'b1;

    // Table vectors
    for (int i = 0; i < 17; i++) begin
      key_mode_n  = tbl[i].km;
      key_speed_n = tbl[i].ks;
      run_en      = tbl[i].run;
      repeat (tbl[i].n) cyc();
      chk("vec_mode", 8'(mode), 8'(tbl[i].exp_mode));
      chk("vec_speed", 8'(speed_sel), 8'(tbl[i].exp_spd));
      chk("vec_tick", 8'(step_tick), 8'(tbl[i].exp_tick));
      $display("vec %0d: km=%0b ks=%0b run=%0b n=%0d -> mode=%0b speed=%0d tick=%0b",
               i, tbl[i].km, tbl[i].ks, tbl[i].run, tbl[i].n, mode, speed_sel, step_tick);
    end

    // Free run from reset: tick every 16 clocks, first one 16 clocks after release
    run_en = 1'b1;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      cyc();
      chk("run_tick", 8'(step_tick), 8'((i % 16) == 0));
    end
    chk("run_mode", 8'(mode), 8'd0);
    chk("run_speed", 8'(speed_sel), 8'd0);
    $display("free run: 40 clocks at speed 0");

    // Speed presses: periods 8,4,2,16, no tick on the press edge
    for (int i = 0; i < 4; i++) begin
      key_speed_n = 1'b0;
      prev_spd = speed_sel;
      n = 0;
      do begin
        cyc();
        n++;
      end while (speed_sel == prev_spd && n < 20);
      key_speed_n = 1'b1;
      chk("speed_latency", 8'(n), 8'(DEB + 2));
      chk("speed_step", 8'(speed_sel), 8'((i + 1) % 4));
      chk("press_no_tick", 8'(step_tick), 8'd0);
      wait_tick("first_tick_seen", 40, n);
      chk("period_first", 8'(n), 8'(plist[i]));
      wait_tick("next_tick_seen", 40, n);
      chk("period_next", 8'(n), 8'(plist[i]));
      $display("speed press %0d: speed_sel=%0d period=%0d", i, speed_sel, n);
    end

    // Pause / resume, then reset in the middle of a tick
    do_reset();
    key_mode_n = 1'b0;
    repeat (DEB + 2) cyc();
    key_mode_n = 1'b1;
    chk("t5_mode_press", 8'(mode), 8'd1);
    wait_tick("t5_tick_seen", 40, n);
    repeat (5) cyc();
    run_en = 1'b0;
    cnt = 0;
    repeat (40) begin
      cyc();
      if (step_tick) cnt++;
    end
    chk("pause_ticks", 8'(cnt), 8'd0);
    run_en = 1'b1;
    wait_tick("resume_seen", 40, n);
    chk("resume_period", 8'(n), 8'd16);
    key_speed_n = 1'b0;
    repeat (DEB + 2) cyc();
    key_speed_n = 1'b1;
    chk("t5_speed", 8'(speed_sel), 8'd1);
    wait_tick("t5_fast_seen", 40, n);
    chk("t5_fast_period", 8'(n), 8'd8);
    async_reset_check("midtick_rst");
    wait_tick("post_rst_seen", 40, n);
    chk("post_rst_period", 8'(n), 8'd16);
    $display("pause/resume and async reset sequence done");

`ifdef LED_RUN_CTRL_AUTO_REV_EN
    // Automatic reversal every 16 ticks, restarted by a mode press
    do_reset();
    for (int t = 1; t <= 32; t++) begin
      wait_tick("auto_tick_seen", 40, n);
      if (t == 15) chk("auto_15", 8'(mode), 8'd0);
      if (t == 16) chk("auto_16", 8'(mode), 8'd1);
      if (t == 31) chk("auto_31", 8'(mode), 8'd1);
      if (t == 32) chk("auto_32", 8'(mode), 8'd0);
    end
    repeat (5) wait_tick("auto_pre_seen", 40, n);
    pm = mode;
    key_mode_n = 1'b0;
    n = 0;
    do begin
      cyc();
      n++;
    end while (mode == pm && n < 20);
    key_mode_n = 1'b1;
    chk("auto_press", 8'(mode), 8'(!pm));
    pm = mode;
    for (int t = 1; t <= 16; t++) begin
      wait_tick("auto_post_seen", 40, n);
      if (t == 15) chk("auto_post_15", 8'(mode), 8'(pm));
      if (t == 16) chk("auto_post_16", 8'(mode), 8'(!pm));
    end
    $display("auto reverse sequence done");
`endif

    // Random run against the reference model
    do_reset();
    hm = 0;
    hs = 0;
    hr = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hm == 0) begin
        key_mode_n = 1'($urandom_range(0, 1));
        hm = $urandom_range(1, 12);
      end
      if (hs == 0) begin
        key_speed_n = 1'($urandom_range(0, 1));
        hs = $urandom_range(1, 12);
      end
      if (hr == 0) begin
        run_en = ($urandom_range(0, 3) != 0);
        hr = $urandom_range(5, 60);
      end
      hm--;
      hs--;
      hr--;
      if ($urandom_range(0, 399) == 0) begin
        async_reset_check("rnd_rst");
        $display("random: async reset at edge %0d", k);
      end
      cyc();
    end
    $display("random: 3000 clocks compared");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
